// File: rtl/axi_slave_write_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_slave_write_resp
// Purpose  : AXI3/AXI4 write slave: one burst at a time, registered memory
//            write port, one B response per burst. Optional 4 KB page check
//            on INCR bursts when AXI_SLV_4K_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module axi_slave_write_resp #(
  parameter int  ID_W     = 12,
  parameter int  ADDR_W   = 32,
  parameter int  DATA_W   = 64,
  parameter int  MAX_SIZE = 3,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ID_W-1:0]   s_axi_wid,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_awready, r_wready, r_bvalid;
  logic              w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [ID_W-1:0]   r_id, r_bid;
  logic [1:0]        r_bresp;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_burst_err, r_wlast_err;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;

  logic w_aw_hs, w_w_hs, w_b_hs, w_last_beat;
  logic w_wrap_len_ok, w_4k_err, w_aw_err;
  logic [ADDR_W-1:0] w_step, w_addr_inc, w_span_mask, w_addr_nxt;
  logic w_unused_wid;

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;

  // WID carries no information for a single-outstanding slave.
  assign w_unused_wid = ^s_axi_wid;

  assign w_aw_hs     = s_axi_awvalid & r_awready;
  assign w_w_hs      = s_axi_wvalid & r_wready;
  assign w_b_hs      = r_bvalid & s_axi_bready;
  assign w_last_beat = (r_cnt == r_len);

  assign w_wrap_len_ok = (s_axi_awlen == 8'd1) | (s_axi_awlen == 8'd3) |
                         (s_axi_awlen == 8'd7) | (s_axi_awlen == 8'd15);

`ifdef AXI_SLV_4K_CHECK_EN
  assign w_4k_err = (s_axi_awburst == 2'b01) &&
      (((s_axi_awaddr + ((ADDR_W'(s_axi_awlen) + ADDR_W'(1)) << s_axi_awsize)
         - ADDR_W'(1)) >> 12) != (s_axi_awaddr >> 12));
`else
  assign w_4k_err = 1'b0;
`endif

  assign w_aw_err = (s_axi_awburst == 2'b11) | (s_axi_awsize > 3'(MAX_SIZE)) |
                    ((s_axi_awburst == 2'b10) & ~w_wrap_len_ok) | w_4k_err;

  // WRAP keeps the bits above the burst span and increments only inside it.
  assign w_step      = ADDR_W'(1) << r_size;
  assign w_addr_inc  = r_addr + w_step;
  assign w_span_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

  always_comb begin
    w_addr_nxt = w_addr_inc;
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = (r_addr & ~w_span_mask) | (w_addr_inc & w_span_mask);
      default: w_addr_nxt = w_addr_inc;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs) begin
          w_state_nxt  = S_DATA;
          w_wready_nxt = 1'b1;
        end else begin
          w_awready_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (w_w_hs && w_last_beat) begin
          w_state_nxt  = S_RESP;
          w_bvalid_nxt = 1'b1;
        end else begin
          w_wready_nxt = 1'b1;
        end
      end
      S_RESP: begin
        if (w_b_hs) begin
          w_state_nxt   = S_IDLE;
          w_awready_nxt = 1'b1;
        end else begin
          w_bvalid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_id        <= '0;
      r_bid       <= '0;
      r_bresp     <= 2'b00;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_burst_err <= 1'b0;
      r_wlast_err <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_mem_we  <= 1'b0;
      if (w_aw_hs) begin
        r_id        <= s_axi_awid;
        r_addr      <= s_axi_awaddr;
        r_len       <= s_axi_awlen;
        r_size      <= s_axi_awsize;
        r_burst     <= s_axi_awburst;
        r_cnt       <= '0;
        r_burst_err <= w_aw_err;
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_mem_we    <= ~r_burst_err;
        r_mem_addr  <= r_addr;
        r_mem_wdata <= s_axi_wdata;
        r_mem_wstrb <= s_axi_wstrb;
        r_addr      <= w_addr_nxt;
        r_cnt       <= r_cnt + 8'd1;
        if (s_axi_wlast != w_last_beat) r_wlast_err <= 1'b1;
        // Final beat's own wlast is folded in directly: the sticky flag lands too late.
        if (w_last_beat) begin
          r_bid   <= r_id;
          r_bresp <= (r_burst_err | r_wlast_err | ~s_axi_wlast) ? 2'b10 : 2'b00;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_write_resp
// Purpose  : Directed self-checking bench for axi_slave_write_resp.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_slave_write_resp;

  localparam int ID_W   = 12;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int LIMIT  = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [7:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [ID_W-1:0]   wid = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [STRB_W-1:0] wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  logic [STRB_W-1:0] ws[$];

  always #5 clk = ~clk;

  axi_slave_write_resp #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SIZE(3)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  // Record every memory write pulse just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      ws.push_back(mem_wstrb);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); ws.delete();
  endtask

  task automatic check_addrs(input string tag, input int n, input logic [ADDR_W-1:0] ea [8]);
    logic [ADDR_W-1:0] got;
    check_val({tag, "_count"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < wa.size()) ? wa[i] : 'x;
      check_val($sformatf("%s_addr%0d", tag, i), 64'(got), 64'(ea[i]));
    end
  endtask

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    check_val("aw_accept", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    check_val("w_accept", 64'(wready), 64'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Waits for B, keeps bready low for 'hold' cycles, then completes the handshake.
  task automatic get_b(input int hold, input logic [ID_W-1:0] eid, input logic [1:0] eresp);
    int n = 0;
    bready = 1'b0;
    while (bvalid !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    check_val("bvalid_seen", 64'(bvalid), 64'd1);
    check_val("bid", 64'(bid), 64'(eid));
    check_val("bresp", 64'(bresp), 64'(eresp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("bvalid_hold", 64'(bvalid), 64'd1);
      check_val("bid_hold", 64'(bid), 64'(eid));
      check_val("bresp_hold", 64'(bresp), 64'(eresp));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("bvalid_drop", 64'(bvalid), 64'd0);
    check_val("awready_after_b", 64'(awready), 64'd1);
  endtask

  // bad_last >= 0 moves the single wlast to that beat index.
  task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int bad_last, input int hold, input logic [1:0] eresp);
    clear_log();
    send_aw(id, a, len, size, burst);
    for (int i = 0; i <= int'(len); i++)
      send_w(64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF,
             (bad_last >= 0) ? (i == bad_last) : (i == int'(len)));
    get_b(hold, id, eresp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_awready"}, 64'(awready), 64'd0);
    check_val({tag, "_wready"}, 64'(wready), 64'd0);
    check_val({tag, "_bvalid"}, 64'(bvalid), 64'd0);
    check_val({tag, "_bid"}, 64'(bid), 64'd0);
    check_val({tag, "_bresp"}, 64'(bresp), 64'd0);
    check_val({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check_val({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check_val({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ea [8];

    // Reset values and first awready after release
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_val("awready_after_rst", 64'(awready), 64'd1);

    // INCR single beat, W presented before AW must stall
    clear_log();
    wdata = 64'hDEADBEEF; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check_val("early_w_stall", 64'(wready), 64'd0);
    send_aw(12'h05A, 32'h1000, 8'd0, 3'd3, 2'b01);
    send_w(64'hDEADBEEF, 8'hFF, 1'b1);
    get_b(0, 12'h05A, 2'b00);
    ea = '{32'h1000, 0, 0, 0, 0, 0, 0, 0};
    check_addrs("single", 1, ea);
    check_val("single_data", (wd.size() > 0) ? wd[0] : 'x, 64'hDEADBEEF);
    check_val("single_strb", 64'((ws.size() > 0) ? ws[0] : 'x), 64'hFF);

    // INCR 4 beats size 2, bready low 3 cycles
    run_burst(12'h011, 32'h20, 8'd3, 3'd2, 2'b01, -1, 3, 2'b00);
    ea = '{32'h20, 32'h24, 32'h28, 32'h2C, 0, 0, 0, 0};
    check_addrs("incr4", 4, ea);
    check_val("incr4_data3", (wd.size() > 3) ? wd[3] : 'x, 64'hC0DE_0000_0000_0003);

    // WRAP len 3 size 3 from 0x118
    run_burst(12'h022, 32'h118, 8'd3, 3'd3, 2'b10, -1, 0, 2'b00);
    ea = '{32'h118, 32'h100, 32'h108, 32'h110, 0, 0, 0, 0};
    check_addrs("wrap4", 4, ea);

    // FIXED burst keeps the address
    run_burst(12'h033, 32'h200, 8'd2, 3'd3, 2'b00, -1, 0, 2'b00);
    ea = '{32'h200, 32'h200, 32'h200, 0, 0, 0, 0, 0};
    check_addrs("fixed3", 3, ea);

    // Reserved burst type and oversize beat: no writes, SLVERR
    run_burst(12'h044, 32'h300, 8'd1, 3'd3, 2'b11, -1, 0, 2'b10);
    check_val("rsvd_no_we", 64'(wa.size()), 64'd0);
    run_burst(12'h045, 32'h300, 8'd1, 3'd4, 2'b01, -1, 0, 2'b10);
    check_val("size4_no_we", 64'(wa.size()), 64'd0);

    // WRAP with illegal length
    run_burst(12'h046, 32'h300, 8'd2, 3'd3, 2'b10, -1, 0, 2'b10);
    check_val("wraplen_no_we", 64'(wa.size()), 64'd0);

    // INCR len 3 with wlast on beat 1: all beats written, SLVERR
    run_burst(12'h055, 32'h400, 8'd3, 3'd3, 2'b01, 1, 0, 2'b10);
    ea = '{32'h400, 32'h408, 32'h410, 32'h418, 0, 0, 0, 0};
    check_addrs("badlast", 4, ea);

    // Missing wlast on the final beat alone
    run_burst(12'h056, 32'h500, 8'd1, 3'd3, 2'b01, 5, 0, 2'b10);
    check_val("nolast_count", 64'(wa.size()), 64'd2);

    // Reset during beat 2 of an 8-beat burst
    clear_log();
    send_aw(12'h066, 32'h40, 8'd7, 3'd3, 2'b01);
    send_w(64'h1, 8'hFF, 1'b0);
    send_w(64'h2, 8'hFF, 1'b0);
    wdata = 64'h3; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    check_val("midrst_prior_we", 64'(wa.size()), 64'd2);
    clear_log();
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check_val("midrst_awready", 64'(awready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check_val("midrst_no_b", 64'(bvalid), 64'd0);
    end
    check_val("midrst_no_we", 64'(wa.size()), 64'd0);

    // INCR crossing a 4 KB page
`ifdef AXI_SLV_4K_CHECK_EN
    run_burst(12'h077, 32'hFF8, 8'd1, 3'd3, 2'b01, -1, 0, 2'b10);
    check_val("page_no_we", 64'(wa.size()), 64'd0);
`else
    run_burst(12'h077, 32'hFF8, 8'd1, 3'd3, 2'b01, -1, 0, 2'b00);
    ea = '{32'hFF8, 32'h1000, 0, 0, 0, 0, 0, 0};
    check_addrs("page", 2, ea);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
